// File: rtl/alu_exec_unit_if.sv
// Signal bundle between the EX-stage control/datapath and alu_exec_unit.
// master drives operands and controls; slave (the ALU) returns results and flags.
interface alu_exec_unit_if;
   logic [31:0] pc;
   logic [31:0] pc_plus4;
   logic [31:0] br_pc_plus4;
   logic [31:0] br_imm;
   logic [31:0] br_target;
   logic [3:0]  alu_op;
   logic [31:0] imm;
   logic [31:0] op_a;
   logic [31:0] op_b;
   logic [3:0]  alu_ctrl;
   logic [31:0] result;
   logic        zero;
   logic        overflow;
   logic        illegal;
   logic        ovf_clr;
   logic        ovf_sticky;

   modport master (
      output pc, br_pc_plus4, br_imm, alu_op, imm, op_a, op_b, ovf_clr,
      input  pc_plus4, br_target, alu_ctrl, result, zero, overflow, illegal, ovf_sticky
   );

   modport slave (
      input  pc, br_pc_plus4, br_imm, alu_op, imm, op_a, op_b, ovf_clr,
      output pc_plus4, br_target, alu_ctrl, result, zero, overflow, illegal, ovf_sticky
   );
endinterface

// File: rtl/alu_exec_unit.sv
// MIPS EX-stage ALU with ALUOp/funct decode, PC+4 and branch-target adders, sticky overflow.
// Define ALU_SHIFT_EN to include SLL/SRL/SRA; otherwise those functs decode as illegal.
module alu_exec_unit (
   input logic           clk,
   input logic           reset,
   alu_exec_unit_if.slave bus
);
   localparam logic [3:0] C_AND   = 4'd0;
   localparam logic [3:0] C_OR    = 4'd1;
   localparam logic [3:0] C_ADD   = 4'd2;
   localparam logic [3:0] C_XOR   = 4'd3;
   localparam logic [3:0] C_ADDU  = 4'd4;
   localparam logic [3:0] C_SUBU  = 4'd5;
   localparam logic [3:0] C_SUB   = 4'd6;
   localparam logic [3:0] C_SLT   = 4'd7;
   localparam logic [3:0] C_SLL   = 4'd8;
   localparam logic [3:0] C_SRL   = 4'd9;
   localparam logic [3:0] C_SRA   = 4'd10;
   localparam logic [3:0] C_SLTU  = 4'd11;
   localparam logic [3:0] C_NOR   = 4'd12;
   localparam logic [3:0] C_LUI   = 4'd13;
   localparam logic [3:0] C_ILL   = 4'd15;

   logic [5:0]  funct;
   logic [4:0]  shamt;
   logic [3:0]  ctrl;
   logic [31:0] sum;
   logic [31:0] diff;
   logic [31:0] res;
   logic        ovf;
   logic        ill;
   logic [3:0]  alu_ctrl;
   logic [31:0] result;
   logic        overflow;
   logic        illegal;
   logic        ovf_sticky;

   assign funct = bus.imm[5:0];
   assign shamt = bus.imm[10:6];

   // Adders are outside the reset gating so fetch keeps running during reset.
   assign bus.pc_plus4  = bus.pc + 32'd4;
   assign bus.br_target = bus.br_pc_plus4 + {bus.br_imm[29:0], 2'b00};

   always_comb begin
      ctrl = C_ILL;
      case (bus.alu_op)
         4'b0000: ctrl = C_ADD;
         4'b0001: ctrl = C_SUB;
         4'b0010: begin
            case (funct)
               6'b100000: ctrl = C_ADD;
               6'b100001: ctrl = C_ADDU;
               6'b100010: ctrl = C_SUB;
               6'b100011: ctrl = C_SUBU;
               6'b100100: ctrl = C_AND;
               6'b100101: ctrl = C_OR;
               6'b100110: ctrl = C_XOR;
               6'b100111: ctrl = C_NOR;
               6'b101010: ctrl = C_SLT;
               6'b101011: ctrl = C_SLTU;
`ifdef ALU_SHIFT_EN
               6'b000000: ctrl = C_SLL;
               6'b000010: ctrl = C_SRL;
               6'b000011: ctrl = C_SRA;
`endif
               default:   ctrl = C_ILL;
            endcase
         end
         4'b0011: ctrl = C_AND;
         4'b0100: ctrl = C_OR;
         4'b0101: ctrl = C_SLT;
         4'b0110: ctrl = C_LUI;
         4'b0111: ctrl = C_XOR;
         4'b1000: ctrl = C_ADDU;
         4'b1001: ctrl = C_SLTU;
         default: ctrl = C_ILL;
      endcase
   end

   assign sum  = bus.op_a + bus.op_b;
   assign diff = bus.op_a - bus.op_b;

   always_comb begin
      res = 32'd0;
      ovf = 1'b0;
      ill = 1'b0;
      case (ctrl)
         C_AND:  res = bus.op_a & bus.op_b;
         C_OR:   res = bus.op_a | bus.op_b;
         C_ADD: begin
            res = sum;
            ovf = (bus.op_a[31] == bus.op_b[31]) && (sum[31] != bus.op_a[31]);
         end
         C_XOR:  res = bus.op_a ^ bus.op_b;
         C_ADDU: res = sum;
         C_SUBU: res = diff;
         C_SUB: begin
            res = diff;
            ovf = (bus.op_a[31] != bus.op_b[31]) && (diff[31] != bus.op_a[31]);
         end
         C_SLT:  res = {31'd0, $signed(bus.op_a) < $signed(bus.op_b)};
         C_SLTU: res = {31'd0, bus.op_a < bus.op_b};
         C_NOR:  res = ~(bus.op_a | bus.op_b);
         C_LUI:  res = {bus.op_b[15:0], 16'h0000};
`ifdef ALU_SHIFT_EN
         C_SLL:  res = bus.op_b << shamt;
         C_SRL:  res = bus.op_b >> shamt;
         C_SRA:  res = $signed(bus.op_b) >>> shamt;
`endif
         default: ill = 1'b1;
      endcase
   end

   // Reset forces a quiet, zero-valued ALU output independent of the clock.
   always_comb begin
      alu_ctrl = 4'd0;
      result   = 32'd0;
      overflow = 1'b0;
      illegal  = 1'b0;
      if (reset) begin
         alu_ctrl = ctrl;
         result   = res;
         overflow = ovf;
         illegal  = ill;
      end
   end

   // Set has priority over clear so a same-cycle overflow is never lost.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         ovf_sticky <= 1'b0;
      else if (overflow)
         ovf_sticky <= 1'b1;
      else if (bus.ovf_clr)
         ovf_sticky <= 1'b0;
   end

   assign bus.alu_ctrl   = alu_ctrl;
   assign bus.result     = result;
   assign bus.zero       = (result == 32'd0);
   assign bus.overflow   = overflow;
   assign bus.illegal    = illegal;
   assign bus.ovf_sticky = ovf_sticky;

`ifdef ALU_SHIFT_EN
   logic unused_bits;
   assign unused_bits = ^{bus.imm[31:11], bus.br_imm[31:30]};
`else
   logic unused_bits;
   assign unused_bits = ^{bus.imm[31:6], bus.br_imm[31:30]};
`endif
endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed self-checking bench for alu_exec_unit; shift expectations follow ALU_SHIFT_EN.
module tb_alu_exec_unit;
   logic clk;
   logic reset;
   int   n_cmp;
   int   n_err;

   alu_exec_unit_if bus ();

   alu_exec_unit dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic [3:0] op, input logic [31:0] im,
                        input logic [31:0] a, input logic [31:0] b);
      bus.alu_op = op;
      bus.imm    = im;
      bus.op_a   = a;
      bus.op_b   = b;
      #1;
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      reset = 1'b0;
      bus.ovf_clr     = 1'b0;
      bus.pc          = 32'hFFFF_FFFC;
      bus.br_pc_plus4 = 32'h0000_0100;
      bus.br_imm      = 32'hFFFF_FFFF;
      drive(4'b0000, 32'd0, 32'h7FFF_FFFF, 32'h0000_0001);

      // reset state, adders still live
      chk("rst_result",   bus.result, 32'h0);
      chk("rst_zero",     32'(bus.zero), 32'h1);
      chk("rst_ovf",      32'(bus.overflow), 32'h0);
      chk("rst_illegal",  32'(bus.illegal), 32'h0);
      chk("rst_ctrl",     32'(bus.alu_ctrl), 32'h0);
      chk("rst_sticky",   32'(bus.ovf_sticky), 32'h0);
      chk("pc_wrap",      bus.pc_plus4, 32'h0000_0000);
      chk("br_neg",       bus.br_target, 32'h0000_00FC);

      @(negedge clk);
      reset = 1'b1;
      #1;
      chk("add_ovf_res",  bus.result, 32'h8000_0000);
      chk("add_ovf",      32'(bus.overflow), 32'h1);
      chk("add_ctrl",     32'(bus.alu_ctrl), 32'h2);
      chk("add_zero",     32'(bus.zero), 32'h0);
      chk("sticky_pre",   32'(bus.ovf_sticky), 32'h0);
      @(posedge clk); #1;
      chk("sticky_set",   32'(bus.ovf_sticky), 32'h1);

      @(negedge clk);
      drive(4'b0000, 32'd0, 32'h1, 32'h1);
      chk("add_res",      bus.result, 32'h2);
      chk("add_noovf",    32'(bus.overflow), 32'h0);
      @(posedge clk); #1;
      chk("sticky_hold",  32'(bus.ovf_sticky), 32'h1);
      @(negedge clk);
      bus.ovf_clr = 1'b1;
      @(posedge clk); #1;
      chk("sticky_clr",   32'(bus.ovf_sticky), 32'h0);

      @(negedge clk);
      drive(4'b0001, 32'd0, 32'h8000_0000, 32'h1);
      chk("sub_ovf_res",  bus.result, 32'h7FFF_FFFF);
      chk("sub_ovf",      32'(bus.overflow), 32'h1);
      @(posedge clk); #1;
      chk("sticky_setwins", 32'(bus.ovf_sticky), 32'h1);
      @(negedge clk);
      drive(4'b0000, 32'd0, 32'h0, 32'h0);
      @(posedge clk); #1;
      chk("sticky_clr2",  32'(bus.ovf_sticky), 32'h0);
      bus.ovf_clr = 1'b0;

      @(negedge clk);
      drive(4'b0010, 32'h22, 32'h1234_5678, 32'h1234_5678);
      chk("rsub_res",     bus.result, 32'h0);
      chk("rsub_zero",    32'(bus.zero), 32'h1);
      chk("rsub_ctrl",    32'(bus.alu_ctrl), 32'h6);

      drive(4'b0101, 32'd0, 32'hFFFF_FFFF, 32'h1);
      chk("slt_res",      bus.result, 32'h1);
      chk("slt_ctrl",     32'(bus.alu_ctrl), 32'h7);
      drive(4'b1001, 32'd0, 32'hFFFF_FFFF, 32'h1);
      chk("sltu_res",     bus.result, 32'h0);
      chk("sltu_ctrl",    32'(bus.alu_ctrl), 32'hB);
      drive(4'b0010, 32'h2A, 32'hFFFF_FFFF, 32'h1);
      chk("rslt_res",     bus.result, 32'h1);
      drive(4'b0010, 32'h2B, 32'h1, 32'hFFFF_FFFF);
      chk("rsltu_res",    bus.result, 32'h1);

      drive(4'b0010, 32'h103, 32'h0, 32'h8000_0000);
`ifdef ALU_SHIFT_EN
      chk("sra_res",      bus.result, 32'hF800_0000);
      chk("sra_ctrl",     32'(bus.alu_ctrl), 32'hA);
      chk("sra_ill",      32'(bus.illegal), 32'h0);
`else
      chk("sra_res",      bus.result, 32'h0);
      chk("sra_ctrl",     32'(bus.alu_ctrl), 32'hF);
      chk("sra_ill",      32'(bus.illegal), 32'h1);
`endif
      drive(4'b0010, 32'h102, 32'h0, 32'h8000_0000);
`ifdef ALU_SHIFT_EN
      chk("srl_res",      bus.result, 32'h0800_0000);
`else
      chk("srl_res",      bus.result, 32'h0);
`endif
      drive(4'b0010, 32'h100, 32'h0, 32'h0000_0001);
`ifdef ALU_SHIFT_EN
      chk("sll_res",      bus.result, 32'h0000_0010);
`else
      chk("sll_ill",      32'(bus.illegal), 32'h1);
`endif

      drive(4'b0110, 32'd0, 32'h0, 32'h0000_ABCD);
      chk("lui_res",      bus.result, 32'hABCD_0000);
      chk("lui_ctrl",     32'(bus.alu_ctrl), 32'hD);

      drive(4'b1011, 32'd0, 32'h5, 32'h7);
      chk("ill_ctrl",     32'(bus.alu_ctrl), 32'hF);
      chk("ill_flag",     32'(bus.illegal), 32'h1);
      chk("ill_res",      bus.result, 32'h0);
      chk("ill_zero",     32'(bus.zero), 32'h1);
      drive(4'b0010, 32'h3F, 32'h5, 32'h7);
      chk("ill_funct",    32'(bus.illegal), 32'h1);

      drive(4'b0010, 32'h27, 32'h0F0F_0000, 32'h0000_00F0);
      chk("nor_res",      bus.result, 32'hF0F0_FF0F);
      chk("nor_ctrl",     32'(bus.alu_ctrl), 32'hC);
      drive(4'b0011, 32'd0, 32'hFF00_FF00, 32'h0F0F_0F0F);
      chk("and_res",      bus.result, 32'h0F00_0F00);
      chk("and_ctrl",     32'(bus.alu_ctrl), 32'h0);
      drive(4'b0100, 32'd0, 32'hFF00_FF00, 32'h0F0F_0F0F);
      chk("or_res",       bus.result, 32'hFF0F_FF0F);
      chk("or_ctrl",      32'(bus.alu_ctrl), 32'h1);
      drive(4'b0111, 32'd0, 32'hFF00_FF00, 32'h0F0F_0F0F);
      chk("xor_res",      bus.result, 32'hF00F_F00F);
      chk("xor_ctrl",     32'(bus.alu_ctrl), 32'h3);
      drive(4'b1000, 32'd0, 32'h7FFF_FFFF, 32'h1);
      chk("addu_res",     bus.result, 32'h8000_0000);
      chk("addu_noovf",   32'(bus.overflow), 32'h0);
      chk("addu_ctrl",    32'(bus.alu_ctrl), 32'h4);
      drive(4'b0010, 32'h23, 32'h8000_0000, 32'h1);
      chk("subu_res",     bus.result, 32'h7FFF_FFFF);
      chk("subu_noovf",   32'(bus.overflow), 32'h0);
      chk("subu_ctrl",    32'(bus.alu_ctrl), 32'h5);
      drive(4'b0010, 32'h20, 32'h8000_0000, 32'h8000_0000);
      chk("radd_ovf",     32'(bus.overflow), 32'h1);
      chk("radd_zero",    32'(bus.zero), 32'h1);

      bus.pc          = 32'h0040_0000;
      bus.br_pc_plus4 = 32'h0000_1000;
      bus.br_imm      = 32'h0000_0010;
      #1;
      chk("pc_plus4",     bus.pc_plus4, 32'h0040_0004);
      chk("br_pos",       bus.br_target, 32'h0000_1040);

      // mid-cycle async reset with sticky set
      @(negedge clk);
      drive(4'b0000, 32'd0, 32'h7FFF_FFFF, 32'h1);
      @(posedge clk); #1;
      chk("sticky_pre_rst", 32'(bus.ovf_sticky), 32'h1);
      #2;
      reset = 1'b0;
      #1;
      chk("async_sticky", 32'(bus.ovf_sticky), 32'h0);
      chk("async_result", bus.result, 32'h0);
      chk("async_zero",   32'(bus.zero), 32'h1);
      chk("async_ovf",    32'(bus.overflow), 32'h0);
      @(negedge clk); #2;
      reset = 1'b1;
      #1;
      chk("rel_result",   bus.result, 32'h8000_0000);
      chk("rel_sticky",   32'(bus.ovf_sticky), 32'h0);
      @(posedge clk); #1;
      chk("rel_sticky_edge", 32'(bus.ovf_sticky), 32'h1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
